// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: CPU output-port UART transmitter.
// OUT writes land in a small FIFO that is drained continuously as 8N1
// frames on txd. A status byte {5'b0, ovf, busy, full} is exported for the
// CPU input-port mux.
// Optional build macro OUT_PORT_UART_TX_PARITY_EN inserts an even-parity
// bit between the data bits and the stop bit (8E1 frame).
module out_port_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [7:0] wd,
    input  logic       clr_ovf,
    output logic       txd,
    output logic       full,
    output logic       busy,
    output logic [7:0] status
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef OUT_PORT_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_ovf;
`ifdef OUT_PORT_UART_TX_PARITY_EN
    logic          r_par;
`endif

    state_t        w_state_nxt;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_txd_nxt;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic          w_bit_end;
    logic [7:0]    w_head;

    assign w_full    = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = we & ~w_full;
    assign w_bit_end = (r_baud == BW'(CLKS_PER_BIT - 1));
    assign w_head    = r_mem[r_rd_ptr];

    // Next-state / next-output logic; txd is computed one cycle ahead so it
    // can be registered and stay glitch-free.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_bit_end ? '0 : r_baud + BW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_txd_nxt  = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = S_START;
                    w_txd_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                    w_txd_nxt   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef OUT_PORT_UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_txd_nxt   = r_par;
`else
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end else begin
                        w_txd_nxt = r_shift[1];
                    end
                end
            end
`ifdef OUT_PORT_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    // Back-to-back frames: reload straight into START.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = S_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    // Transmitter state, counters, shift register and registered txd.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

`ifdef OUT_PORT_UART_TX_PARITY_EN
    // Parity of the frame being sent, captured when the word is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_par <= 1'b0;
        else if (w_pop)
            r_par <= ^w_head;
    end
`endif

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wd;
    end

    // FIFO pointers and occupancy; push+pop together keeps count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a write into a full FIFO wins over a same-edge clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (we && w_full)
            r_ovf <= 1'b1;
        else if (clr_ovf)
            r_ovf <= 1'b0;
    end

    assign txd    = r_txd;
    assign full   = w_full;
    assign busy   = (r_state != S_IDLE) | ~w_empty;
    assign status = {5'b0, r_ovf, busy, full};

endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
- Serial transmitter on the CPU output-port side: the datapath's OUT write strobe pushes 8-bit words into a small FIFO.
- The block serialises FIFO words onto txd as UART frames (8N1) and drains them continuously.
- A status byte is exposed for the CPU input-port mux so programs can poll full/busy/overflow.
- It is the transmit end of the serial link whose receive side is handled off-chip.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit period; must be >= 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high.
- we  input  1  CPU output-port write strobe, sampled on the rising clk edge.
- wd  input  8  data word written by the CPU.
- clr_ovf  input  1  synchronous clear of the sticky overflow flag.
- txd  output  1  serial line; idles high.
- full  output  1  FIFO holds FIFO_DEPTH words.
- busy  output  1  FSM not in IDLE, or FIFO non-empty.
- status  output  8  {5'b0, ovf, busy, full}.

Behaviour:
- Reset values (immediately on reset, asynchronously, including mid-frame):
  - txd=1; FIFO empty (rd/wr pointers and count = 0); full=0, busy=0, ovf=0; FSM=IDLE; bit and baud counters = 0.
- FIFO:
  - Circular buffer with count width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Push on an edge where we=1 and full=0 (full as seen before the edge).
  - If we=1 and full=1: the word is dropped and ovf is set. This holds even if a pop occurs on the same edge.
  - A simultaneous push and pop with count between 1 and FIFO_DEPTH-1 leaves count unchanged.
  - full and busy are combinational from registered state.
- ovf:
  - Sticky; clr_ovf=1 clears it.
  - If clr_ovf=1 and an overflow occur on the same edge, set wins (ovf=1).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. On an edge with FIFO non-empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0], LSB first. Each CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
    - At the end of the period, if the FIFO is non-empty: pop and go directly to START (back-to-back frames, no extra idle cycle).
    - Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1; a bit ends on the edge where the counter equals CLKS_PER_BIT-1.
- Latency:
  - Word pushed on edge N into an empty FIFO with FSM IDLE: txd falls after edge N+1.
  - Frame length: 10*CLKS_PER_BIT cycles.
- txd is driven from a register (no combinational glitches).
- A write while a frame is in progress does not disturb the current frame.

Optional Feature:
- Macro: OUT_PORT_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - txd = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined: 8N1 only; the PARITY state and its logic are absent.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset, then write 8'hA5 once -> txd low starting 1 cycle after the write edge for 4 cycles. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. busy=1 throughout and 0 after the stop bit.
2. Write 8'h01 and 8'h80 on consecutive cycles -> two frames with the second start bit immediately after the first stop bit (80 cycles total from first start), no idle gap.
3. With the FSM holding the first word, write 5 more words on consecutive cycles:
   - full=1 after the 4th of those 5.
   - The 5th sets ovf (status=8'b00000111).
   - Exactly 5 frames are transmitted.
   - clr_ovf then gives status bit2=0.
4. Overflow write and clr_ovf on the same edge -> ovf=1 afterwards.
5. Assert reset during DATA bit 3 of frame 8'h3C with 2 words queued -> txd=1 and status=0 immediately; after release, no further frames without new writes.
6. With OUT_PORT_UART_TX_PARITY_EN defined, write 8'h07 -> parity bit=1 after bit 7, frame 44 cycles. Write 8'h03 -> parity bit=0.
